// File: rtl/ddr_wr_pkg.sv
// Shared types and size helpers for the DDR burst writer.
package ddr_wr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    B
  } state_e;

  // Bytes carried by one AXI data beat.
  function automatic int axi_bytes(input int data_w);
    return data_w / 8;
  endfunction

  // Bytes covered by one full-length burst.
  function automatic int burst_bytes(input int data_w, input int burst_len);
    return burst_len * (data_w / 8);
  endfunction

endpackage

// File: rtl/ddr_burst_writer.sv
// Drains the prefetch FIFO into DDR as AXI4 INCR write bursts, one video frame at a time.
// Frame position (address, words remaining) advances burst by burst; frame_start may re-arm at any time.
module ddr_burst_writer
  import ddr_wr_pkg::*;
#(
  parameter int                ADDR_W      = 28,
  parameter int                DATA_W      = 256,
  parameter int                BURST_LEN   = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                FRAME_WORDS = 8100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_W-1:0]     fifo_rd_data,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int                AXI_BYTES   = axi_bytes(DATA_W);
  localparam int                BURST_BYTES = burst_bytes(DATA_W, BURST_LEN);
  localparam int                REM_W       = $clog2(FRAME_WORDS + 1);
  localparam logic [REM_W-1:0]  FRAME_REM   = REM_W'(FRAME_WORDS);
  localparam logic [31:0]       BURST_LEN_U = 32'(BURST_LEN);
  localparam logic [31:0]       AXI_BYTES_U = 32'(AXI_BYTES);

  // Every burst starts on a BURST_BYTES multiple, so alignment plus a 4 KB-dividing span keeps bursts inside a page.
  if ((BASE_ADDR % ADDR_W'(BURST_BYTES)) != '0) begin : g_base_align
    $error("BASE_ADDR must be aligned to BURST_LEN*DATA_W/8");
  end
  if ((BURST_BYTES > 4096) || ((4096 % BURST_BYTES) != 0)) begin : g_page_span
    $error("BURST_LEN*DATA_W/8 must divide 4096");
  end

  state_e              state_q, state_d;
  logic                armed_q, armed_d;
  logic                restart_pend_q, restart_pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REM_W-1:0]    remaining_q, remaining_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic                frame_done_q, frame_done_d;
  logic [31:0]         burst_words;
  logic                restart;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    armed_d        = armed_q;
    restart_pend_d = restart_pend_q;
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    len_d          = len_q;
    beat_d         = beat_q;
    frame_done_d   = 1'b0;
    burst_words    = '0;
    restart        = restart_pend_q | frame_start;
    awvalid        = 1'b0;
    wvalid         = 1'b0;
    wlast          = 1'b0;
    bready         = 1'b0;
    fifo_rd_en     = 1'b0;

    if (frame_start && (state_q != IDLE)) restart_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          armed_d     = 1'b1;
          addr_d      = BASE_ADDR;
          remaining_d = FRAME_REM;
        end
        if (armed_q && fifo_rd_vld) begin
          burst_words = (32'(remaining_d) < BURST_LEN_U) ? 32'(remaining_d) : BURST_LEN_U;
          len_d       = 8'(burst_words - 32'd1);
          beat_d      = '0;
          state_d     = AW;
        end
      end
      AW: begin
        awvalid = 1'b1;
        if (awready) begin
          addr_d  = addr_q + ADDR_W'((32'(len_q) + 32'd1) * AXI_BYTES_U);
          state_d = W;
        end
      end
      W: begin
        wvalid     = fifo_rd_vld;
        wlast      = (beat_q == len_q);
        fifo_rd_en = fifo_rd_vld & wready;
        if (fifo_rd_en) begin
          if (wlast) begin
            remaining_d = remaining_q - REM_W'(32'(len_q) + 32'd1);
            beat_d      = '0;
            state_d     = B;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      B: begin
        bready = 1'b1;
        if (bvalid) begin
          // A restart arriving alongside the last response wins: the old frame is abandoned silently.
          if (restart) begin
            addr_d         = BASE_ADDR;
            remaining_d    = FRAME_REM;
            armed_d        = 1'b1;
            restart_pend_d = 1'b0;
          end else if (remaining_q == '0) begin
            frame_done_d = 1'b1;
            armed_d      = 1'b0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      armed_q        <= 1'b0;
      restart_pend_q <= 1'b0;
      addr_q         <= BASE_ADDR;
      remaining_q    <= FRAME_REM;
      len_q          <= '0;
      beat_q         <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      restart_pend_q <= restart_pend_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      len_q          <= len_d;
      beat_q         <= beat_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign awaddr     = addr_q;
  assign awlen      = len_q;
  assign wdata      = fifo_rd_data;
  assign wstrb      = '1;
  assign busy       = armed_q | (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ddr_burst_writer.sv
// Directed bench for ddr_burst_writer: a 32-word frame instance for most steps, a 20-word one for the short-burst case.
module tb_ddr_burst_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start, fs20;
  logic         fifo_rd_vld;
  logic [255:0] fifo_rd_data;
  logic         awready, wready, bvalid;

  logic         fifo_rd_en, awvalid, wlast, wvalid, bready, busy, frame_done;
  logic [27:0]  awaddr;
  logic [7:0]   awlen;
  logic [255:0] wdata;
  logic [31:0]  wstrb;

  logic         b_fifo_rd_en, b_awvalid, b_wlast, b_wvalid, b_bready, b_busy, b_frame_done;
  logic [27:0]  b_awaddr;
  logic [7:0]   b_awlen;
  logic [255:0] b_wdata;
  logic [31:0]  b_wstrb;

  int checks = 0;
  int failures = 0;

  int data_idx, beats, pops, n_done, pop_err, data_err, mirror_err;
  int b_beats, b_n_done;
  logic in_w;
  logic [27:0] aw_addr[$], b_aw_addr[$];
  logic [7:0]  aw_len[$],  b_aw_len[$];
  int          last_at[$], b_last_at[$];

  always #5 clk = ~clk;

  function automatic logic [255:0] make_word(input int idx);
    return {8{32'hD0000000 | 32'(idx)}};
  endfunction

  assign fifo_rd_data = make_word(data_idx);

  ddr_burst_writer #(.ADDR_W(28), .DATA_W(256), .BURST_LEN(16), .BASE_ADDR(28'h0), .FRAME_WORDS(32)) u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .busy(busy), .frame_done(frame_done)
  );

  ddr_burst_writer #(.ADDR_W(28), .DATA_W(256), .BURST_LEN(16), .BASE_ADDR(28'h0), .FRAME_WORDS(20)) u_dut20 (
    .clk(clk), .rst(rst), .frame_start(fs20),
    .fifo_rd_en(b_fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .awaddr(b_awaddr), .awlen(b_awlen), .awvalid(b_awvalid), .awready(awready),
    .wdata(b_wdata), .wstrb(b_wstrb), .wlast(b_wlast), .wvalid(b_wvalid), .wready(wready),
    .bvalid(bvalid), .bready(b_bready), .busy(b_busy), .frame_done(b_frame_done)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    data_idx = 0; beats = 0; pops = 0; n_done = 0;
    pop_err = 0; data_err = 0; mirror_err = 0; in_w = 1'b0;
    b_beats = 0; b_n_done = 0;
    aw_addr.delete(); aw_len.delete(); last_at.delete();
    b_aw_addr.delete(); b_aw_len.delete(); b_last_at.delete();
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    logic pop;
    @(negedge clk);
    pop = fifo_rd_en;
    if (in_w && (wvalid !== fifo_rd_vld)) mirror_err++;
    if (fifo_rd_en !== (wvalid && wready)) pop_err++;
    if (wvalid && wready) begin
      beats++;
      if (wdata !== make_word(data_idx)) data_err++;
      if (wlast) begin
        last_at.push_back(beats);
        in_w = 1'b0;
      end
    end
    if (awvalid && awready) begin
      aw_addr.push_back(awaddr);
      aw_len.push_back(awlen);
      in_w = 1'b1;
    end
    if (frame_done) n_done++;
    if (b_wvalid && wready) begin
      b_beats++;
      if (b_wlast) b_last_at.push_back(b_beats);
    end
    if (b_awvalid && awready) begin
      b_aw_addr.push_back(b_awaddr);
      b_aw_len.push_back(b_awlen);
    end
    if (b_frame_done) b_n_done++;
    @(posedge clk);
    #1;
    if (pop) begin
      data_idx++;
      pops++;
    end
  endtask

  initial begin
    int n_before;
    rst = 1'b1; frame_start = 1'b0; fs20 = 1'b0; fifo_rd_vld = 1'b1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wlast", wlast, 0);
    check("rst_bready", bready, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_awaddr", awaddr, 28'h0);
    check("rst_awlen", awlen, 8'h0);
    check("rst_wstrb", wstrb, 32'hFFFF_FFFF);
    rst = 1'b0;

    // 1: 32-word frame, everything ready
    clear_stats();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("t1_busy_armed", busy, 1);
    for (int i = 0; i < 200 && n_done == 0; i++) step();
    repeat (3) step();
    check("t1_aw_count", aw_addr.size(), 2);
    if (aw_addr.size() >= 2) begin
      check("t1_awaddr0", aw_addr[0], 28'h0000000);
      check("t1_awaddr1", aw_addr[1], 28'h0000200);
      check("t1_awlen0", aw_len[0], 8'd15);
      check("t1_awlen1", aw_len[1], 8'd15);
    end
    check("t1_pops", pops, 32);
    check("t1_last_count", last_at.size(), 2);
    if (last_at.size() >= 2) begin
      check("t1_wlast0", last_at[0], 16);
      check("t1_wlast1", last_at[1], 32);
    end
    check("t1_done_once", n_done, 1);
    check("t1_data", data_err, 0);
    check("t1_pop_rule", pop_err, 0);
    check("t1_busy_end", busy, 0);

    // 2: 20-word frame gives a short final burst
    clear_stats();
    fs20 = 1'b1; step(); fs20 = 1'b0;
    for (int i = 0; i < 200 && b_n_done == 0; i++) step();
    repeat (3) step();
    check("t2_aw_count", b_aw_addr.size(), 2);
    if (b_aw_addr.size() >= 2) begin
      check("t2_awaddr1", b_aw_addr[1], 28'h0000200);
      check("t2_awlen0", b_aw_len[0], 8'd15);
      check("t2_awlen1", b_aw_len[1], 8'd3);
    end
    check("t2_last_count", b_last_at.size(), 2);
    if (b_last_at.size() >= 2) begin
      check("t2_wlast0", b_last_at[0], 16);
      check("t2_wlast1", b_last_at[1], 20);
    end
    check("t2_beats", b_beats, 20);
    check("t2_done_once", b_n_done, 1);

    // 3: FIFO valid toggles every cycle
    clear_stats();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 100 && last_at.size() == 0; i++) begin
      fifo_rd_vld = ~fifo_rd_vld;
      step();
    end
    fifo_rd_vld = 1'b1;
    check("t3_burst_done", last_at.size(), 1);
    if (last_at.size() >= 1) check("t3_beats16", last_at[0], 16);
    check("t3_mirror", mirror_err, 0);
    check("t3_pops16", pops, 16);
    for (int i = 0; i < 200 && n_done == 0; i++) step();
    check("t3_data", data_err, 0);
    check("t3_pop_rule", pop_err, 0);
    check("t3_pops32", pops, 32);

    // 4: wready stalled for 5 cycles mid-burst
    clear_stats();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 50 && beats < 4; i++) step();
    wready = 1'b0;
    #1;
    check("t4_stall_wvalid0", wvalid, 1);
    check("t4_stall_wdata0", wdata, make_word(4));
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_stall_wvalid", wvalid, 1);
      check("t4_stall_wdata", wdata, make_word(4));
      check("t4_stall_rd_en", fifo_rd_en, 0);
    end
    wready = 1'b1;
    for (int i = 0; i < 200 && n_done == 0; i++) step();
    check("t4_beats", beats, 32);
    check("t4_data", data_err, 0);
    check("t4_done", n_done, 1);

    // 5: restart on beat 5 of the second burst
    clear_stats();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 100 && beats < 20; i++) step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 100 && aw_addr.size() < 3; i++) step();
    check("t5_aw_count", aw_addr.size(), 3);
    check("t5_last_count", last_at.size(), 2);
    if (last_at.size() >= 2) check("t5_full_burst", last_at[1], 32);
    if (aw_addr.size() >= 3) check("t5_restart_addr", aw_addr[2], 28'h0000000);
    check("t5_no_done", n_done, 0);
    for (int i = 0; i < 200 && n_done == 0; i++) step();
    check("t5_beats", beats, 64);
    if (aw_addr.size() >= 4) check("t5_second_addr", aw_addr[3], 28'h0000200);
    check("t5_done", n_done, 1);

    // 6: reset in the middle of a burst
    clear_stats();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 50 && beats < 3; i++) step();
    rst = 1'b1; step();
    check("t6_awvalid", awvalid, 0);
    check("t6_wvalid", wvalid, 0);
    check("t6_wlast", wlast, 0);
    check("t6_bready", bready, 0);
    check("t6_rd_en", fifo_rd_en, 0);
    check("t6_done", frame_done, 0);
    check("t6_busy", busy, 0);
    check("t6_awaddr", awaddr, 28'h0);
    check("t6_awlen", awlen, 8'h0);
    rst = 1'b0;
    in_w = 1'b0;
    n_before = aw_addr.size();
    repeat (20) step();
    check("t6_no_aw", aw_addr.size(), n_before);
    check("t6_idle_busy", busy, 0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 20 && aw_addr.size() == n_before; i++) step();
    check("t6_new_aw", aw_addr.size(), n_before + 1);
    if (aw_addr.size() > n_before) check("t6_new_addr", aw_addr[n_before], 28'h0000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
